// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dm_pkg
// Brief    : Shared size codes, FSM state encoding and counter width for the
//            data-memory responder.
// Revision : 1.0
// ============================================================================
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Wide enough for the full 0..15 wait-state range.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_e;

endpackage
`default_nettype wire

// File: rtl/dm_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : dm_lane_align
// Brief    : Little-endian lane steering: store merge with byte enables, load
//            extraction with sign/zero extension, and alignment checking.
// Revision : 1.0
// ============================================================================
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic        signed_i,
    output logic [31:0] new_word_o,
    output logic [3:0]  byte_en_o,
    output logic [31:0] load_data_o,
    output logic        align_err_o
);

    logic [31:0] w_wrep;
    logic [3:0]  w_be;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store data is replicated across lanes so the enables alone pick the target.
    always_comb begin
        align_err_o = 1'b0;
        w_wrep      = wdata_i;
        w_be        = 4'b0000;
        case (size_i)
            SZ_BYTE: begin
                w_wrep = {4{wdata_i[7:0]}};
                w_be   = 4'b0001 << offset_i;
            end
            SZ_HALF: begin
                w_wrep      = {2{wdata_i[15:0]}};
                w_be        = offset_i[1] ? 4'b1100 : 4'b0011;
                align_err_o = offset_i[0];
            end
            SZ_WORD: begin
                w_be        = 4'b1111;
                align_err_o = (offset_i != 2'b00);
            end
            default: align_err_o = 1'b1;
        endcase
    end

    assign byte_en_o = align_err_o ? 4'b0000 : w_be;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign new_word_o[8*gi +: 8] = byte_en_o[gi] ? w_wrep[8*gi +: 8]
                                                          : word_i[8*gi +: 8];
        end
    endgenerate

    assign w_byte = word_i[{offset_i, 3'b000} +: 8];
    assign w_half = offset_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        load_data_o = '0;
        case (size_i)
            SZ_BYTE: load_data_o = {{24{signed_i & w_byte[7]}}, w_byte};
            SZ_HALF: load_data_o = {{16{signed_i & w_half[15]}}, w_half};
            SZ_WORD: load_data_o = word_i;
            default: load_data_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Memory end of the MEM-stage load/store interface with configurable
//            wait states and valid/ready request and response channels.
// Revision : 1.0
// ============================================================================
module data_mem_responder
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int c_idx_w = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] c_cnt_load =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    dm_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdy_q, rdy_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             we_q;
    logic [1:0]       size_q;
    logic             sgn_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;

    logic [31:0]      mem_q [DEPTH_WORDS];

    logic             w_accept;
    logic             w_in_idle;
    logic             w_cur_we;
    logic [1:0]       w_cur_size;
    logic             w_cur_sgn;
    logic [31:0]      w_cur_addr;
    logic [31:0]      w_cur_wdata;
    logic             w_range_err;
    logic             w_align_err;
    logic             w_err;
    logic [c_idx_w-1:0] w_idx;
    logic [31:0]      w_word;
    logic [31:0]      w_new_word;
    logic [3:0]       w_byte_en;
    logic [31:0]      w_load;
    logic             w_enter_resp;
    logic             w_write;

    // With zero wait states the response is built on the acceptance edge, before
    // the request latch holds anything, so the live request is used then.
    assign w_in_idle   = (state_q == ST_IDLE);
    assign w_cur_we    = w_in_idle ? req_we     : we_q;
    assign w_cur_size  = w_in_idle ? req_size   : size_q;
    assign w_cur_sgn   = w_in_idle ? req_signed : sgn_q;
    assign w_cur_addr  = w_in_idle ? req_addr   : addr_q;
    assign w_cur_wdata = w_in_idle ? req_wdata  : wdata_q;

    assign w_range_err = ({2'b00, w_cur_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign w_err       = w_range_err | w_align_err;
    assign w_idx       = w_range_err ? '0 : w_cur_addr[c_idx_w+1:2];
    assign w_word      = mem_q[w_idx];

    dm_lane_align u_lane_align (
        .word_i      (w_word),
        .wdata_i     (w_cur_wdata),
        .size_i      (w_cur_size),
        .offset_i    (w_cur_addr[1:0]),
        .signed_i    (w_cur_sgn),
        .new_word_o  (w_new_word),
        .byte_en_o   (w_byte_en),
        .load_data_o (w_load),
        .align_err_o (w_align_err)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_accept = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && rdy_q) begin
                    w_accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = c_cnt_load;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rdy_d        = (state_d == ST_IDLE);
    assign w_enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    assign w_write      = w_enter_resp && w_cur_we && !w_err && (w_byte_en != 4'b0000);

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (w_enter_resp) begin
            err_d   = w_err;
            rdata_d = (w_err || w_cur_we) ? '0 : w_load;
        end else if ((state_q == ST_RESP) && rsp_ready) begin
            err_d   = 1'b0;
            rdata_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (w_accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                sgn_q   <= req_signed;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // Storage is deliberately outside the reset domain; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_write) begin
            mem_q[w_idx] <= w_new_word;
        end
    end

    assign req_ready = rdy_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
`default_nettype wire
